// File: rtl/line_buffer_pkg.sv
// line_buffer_pkg: shared state encoding and width helpers for the window sequencer
package line_buffer_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int cnt_w(int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
  function automatic int idx_w(int n);
    return $clog2((n - 1) / 2) + 1;
  endfunction
endpackage

// File: rtl/line_buffer_window_sequencer_if.sv
// line_buffer_window_sequencer_if: upstream pixel, line-buffer load and window handshake signals
interface line_buffer_window_sequencer_if #(parameter int input_y = 5, parameter int input_x = 5);
  logic in_valid, in_sof, in_ready, lb_load;
  logic win_valid, win_ready, win_last, frame_done, err_sof;
  logic [line_buffer_pkg::idx_w(input_x)-1:0] win_row;
  logic [line_buffer_pkg::idx_w(input_y)-1:0] win_col;
  modport master (
    input  in_valid, in_sof, win_ready,
    output in_ready, lb_load, win_valid, win_row, win_col, win_last, frame_done, err_sof
  );
  modport slave (
    output in_valid, in_sof, win_ready,
    input  in_ready, lb_load, win_valid, win_row, win_col, win_last, frame_done, err_sof
  );
endinterface

// File: rtl/line_buffer_window_sequencer_pos_counter.sv
// pos_counter: wrap counter with enable and sync clear; clear with enable restarts counting from zero
module pos_counter #(parameter int w = 3, parameter int max = 4) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [w-1:0] q,
  output logic         wrap
);
  logic [w-1:0] base;
  always_comb begin
    base = clr ? '0 : q;
    wrap = base == w'(max);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else if (en) q <= wrap ? '0 : base + 1'b1;
    else if (clr) q <= '0;
  end
endmodule

// File: rtl/line_buffer_window_sequencer.sv
// line_buffer_window_sequencer: pixel position tracking and stride-2 3x3 window issue around a line buffer
module line_buffer_window_sequencer
  import line_buffer_pkg::*;
#(parameter int input_y = 5, parameter int input_x = 5) (
  input logic clk,
  input logic rst,
  line_buffer_window_sequencer_if.master bus
);
  localparam int rw = cnt_w(input_x);
  localparam int cw = cnt_w(input_y);
  localparam int orw = idx_w(input_x);
  localparam int ocw = idx_w(input_y);
  state_t state, state_nx;
  logic [rw-1:0] row, pos_r;
  logic [cw-1:0] col, pos_c;
  logic accept, load, restart, col_wrap, row_wrap, hit, last_win, take;
  pos_counter #(.w(cw), .max(input_y - 1)) u_col (
    .clk(clk), .rst(rst), .en(load), .clr(restart), .q(col), .wrap(col_wrap)
  );
  pos_counter #(.w(rw), .max(input_x - 1)) u_row (
    .clk(clk), .rst(rst), .en(load & col_wrap), .clr(restart), .q(row), .wrap(row_wrap)
  );
  always_comb begin
    bus.in_ready = !bus.win_valid | bus.win_ready;
    accept = bus.in_valid & bus.in_ready;
    load = accept & (state == RUN | bus.in_sof);
    restart = load & bus.in_sof;
    bus.lb_load = load;
    pos_r = restart ? '0 : row;
    pos_c = restart ? '0 : col;
    state_nx = state == IDLE ? (restart ? RUN : IDLE) : (load & row_wrap & col_wrap ? IDLE : RUN);
    // only even positions from (2,2) close a stride-2 window; stale lines after a restart never qualify
    hit = load && pos_r >= rw'(2) && pos_c >= cw'(2) && !pos_r[0] && !pos_c[0];
    last_win = pos_r >= rw'(input_x - 2) && pos_c >= cw'(input_y - 2);
    take = bus.win_valid & bus.win_ready;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.win_valid <= 1'b0;
      bus.win_row <= '0;
      bus.win_col <= '0;
      bus.win_last <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.err_sof <= 1'b0;
    end else begin
      bus.win_valid <= hit | (bus.win_valid & !bus.win_ready);
      if (hit) begin
        bus.win_row <= orw'((pos_r - rw'(2)) >> 1);
        bus.win_col <= ocw'((pos_c - cw'(2)) >> 1);
        bus.win_last <= last_win;
      end else if (take) bus.win_last <= 1'b0;
      bus.frame_done <= take & bus.win_last;
      bus.err_sof <= restart & (state == RUN);
    end
  end
endmodule

// File: tb/tb_line_buffer_window_sequencer.sv
// tb_line_buffer_window_sequencer: table, directed and random checks of two sequencer instances (5x5 and 7x3)
module tb_line_buffer_window_sequencer;
  logic clk = 1'b0, rst = 1'b0, v = 1'b0, sof = 1'b0, wr = 1'b1;
  bit sel = 1'b0;
  int total = 0, bad = 0, ntake = 0;
  int mx = 5, my = 5, m_k = 0, m_row = 0, m_col = 0;
  bit m_run = 0, m_wv = 0, m_wl = 0, m_fd = 0, m_es = 0;
  int o_ir, o_ld, o_wv, o_row, o_col, o_last, o_fd, o_es;
  always #5 clk = ~clk;
  line_buffer_window_sequencer_if #(.input_y(5), .input_x(5)) a ();
  line_buffer_window_sequencer_if #(.input_y(7), .input_x(3)) b ();
  assign a.in_valid = v;
  assign a.in_sof = sof;
  assign a.win_ready = wr;
  assign b.in_valid = v;
  assign b.in_sof = sof;
  assign b.win_ready = wr;
  line_buffer_window_sequencer #(.input_y(5), .input_x(5)) dut_a (.clk(clk), .rst(rst), .bus(a));
  line_buffer_window_sequencer #(.input_y(7), .input_x(3)) dut_b (.clk(clk), .rst(rst), .bus(b));
  assign o_ir = int'(sel ? b.in_ready : a.in_ready);
  assign o_ld = int'(sel ? b.lb_load : a.lb_load);
  assign o_wv = int'(sel ? b.win_valid : a.win_valid);
  assign o_row = sel ? int'(b.win_row) : int'(a.win_row);
  assign o_col = sel ? int'(b.win_col) : int'(a.win_col);
  assign o_last = int'(sel ? b.win_last : a.win_last);
  assign o_fd = int'(sel ? b.frame_done : a.frame_done);
  assign o_es = int'(sel ? b.err_sof : a.err_sof);

  typedef struct {bit sof; bit wv; int row; int col; bit last; bit fd;} vec_t;
  vec_t tbl[27];

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset(bit s);
    sel = s;
    mx = s ? 3 : 5;
    my = s ? 7 : 5;
    v = 0; sof = 0; wr = 1; rst = 0;
    #3;
    chk("rst in_ready", o_ir, 1);
    chk("rst lb_load", o_ld, 0);
    chk("rst win_valid", o_wv, 0);
    chk("rst frame_done", o_fd, 0);
    chk("rst err_sof", o_es, 0);
    @(posedge clk); #1 rst = 1;
    m_run = 0; m_k = 0; m_wv = 0; m_wl = 0; m_fd = 0; m_es = 0; ntake = 0;
  endtask

  // reference: a frame is a linear pixel index k; position is (k / width, k % width)
  task automatic cycle(bit iv, bit is, bit iw);
    bit rdy, acc, load, take, hit;
    int r, c;
    v = iv; sof = is; wr = iw;
    #2;
    rdy = !m_wv || iw;
    acc = iv && rdy;
    load = acc && (m_run || is);
    chk("in_ready", o_ir, int'(rdy));
    chk("lb_load", o_ld, int'(load));
    if (o_wv == 1 && iw) ntake++;
    take = m_wv && iw;
    m_fd = take && m_wl;
    m_es = acc && is && m_run;
    hit = 0;
    if (load) begin
      if (is) m_k = 0;
      r = m_k / my;
      c = m_k % my;
      hit = r >= 2 && c >= 2 && r % 2 == 0 && c % 2 == 0;
      m_k++;
      m_run = m_k < mx * my;
      if (!m_run) m_k = 0;
      if (hit) begin
        m_row = (r - 2) / 2;
        m_col = (c - 2) / 2;
        m_wl = r >= mx - 2 && c >= my - 2;
      end
    end
    m_wv = hit || (m_wv && !iw);
    @(posedge clk); #1;
    chk("win_valid", o_wv, int'(m_wv));
    chk("frame_done", o_fd, int'(m_fd));
    chk("err_sof", o_es, int'(m_es));
    if (m_wv) begin
      chk("win_row", o_row, m_row);
      chk("win_col", o_col, m_col);
      chk("win_last", o_last, int'(m_wl));
    end
  endtask

  task automatic run_frame(int beats, int sof2);
    for (int i = 0; i < beats; i++) cycle(1'b1, i == 0 || i == sof2, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 27; i++) tbl[i] = '{i == 0, 0, 0, 0, 0, 0};
    tbl[12] = '{0, 1, 0, 0, 0, 0};
    tbl[14] = '{0, 1, 0, 1, 0, 0};
    tbl[22] = '{0, 1, 1, 0, 0, 0};
    tbl[24] = '{0, 1, 1, 1, 1, 0};
    tbl[25].fd = 1;

    do_reset(0);
    for (int i = 0; i < 27; i++) begin
      v = i < 25; sof = tbl[i].sof; wr = 1;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d win_valid", i), o_wv, int'(tbl[i].wv));
      chk($sformatf("tbl%0d frame_done", i), o_fd, int'(tbl[i].fd));
      if (tbl[i].wv) begin
        chk($sformatf("tbl%0d win_row", i), o_row, tbl[i].row);
        chk($sformatf("tbl%0d win_col", i), o_col, tbl[i].col);
        chk($sformatf("tbl%0d win_last", i), o_last, int'(tbl[i].last));
      end
    end
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);

    do_reset(0);
    for (int i = 0; i < 13; i++) cycle(1'b1, i == 0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
    for (int i = 13; i < 25; i++) cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    chk("backpressure windows", ntake, 4);

    do_reset(0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1);
    run_frame(25, -1);
    chk("discard then frame windows", ntake, 4);

    do_reset(0);
    run_frame(35, 10);
    chk("mid-frame sof windows", ntake, 4);

    do_reset(0);
    for (int i = 0; i < 25; i++) cycle(1'b1, i == 0, 1'b1);
    v = 0; wr = 0;
    #2;
    chk("pre-reset win_valid", o_wv, 1);
    chk("pre-reset win_last", o_last, 1);
    rst = 0;
    #1;
    chk("async win_valid", o_wv, 0);
    chk("async win_last", o_last, 0);
    chk("async frame_done", o_fd, 0);
    chk("async err_sof", o_es, 0);
    do_reset(0);
    for (int i = 0; i < 18; i++) cycle(1'b1, i == 0, 1'b1);
    v = 1; sof = 0; wr = 1;
    #2 rst = 0;
    #1;
    chk("beat18 reset win_valid", o_wv, 0);
    chk("beat18 reset lb_load", o_ld, 0);
    do_reset(0);
    run_frame(25, -1);
    chk("after reset windows", ntake, 4);

    do_reset(1);
    run_frame(21, -1);
    chk("7x3 windows", ntake, 3);

    for (int s = 0; s < 2; s++) begin
      do_reset(s[0]);
      for (int i = 0; i < 1500; i++)
        cycle($urandom_range(9) < 8, m_run ? ($urandom_range(63) == 0) : ($urandom_range(2) == 0),
              $urandom_range(9) < 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
